// File: rtl/jpeg_pkg.sv
// Shared JPEG datapath definitions: SRAM geometry, Q8 colour coefficients,
// the 3-word-per-block address map and the ycbcr2rgb_2d FSM state type.
package jpeg_pkg;

  localparam int SRAM_AW       = 11;
  localparam int WORD_W        = 512;
  localparam int SAMPLE_W      = 8;
  localparam int PIX_PER_WORD  = 64;
  localparam int WORDS_PER_BLK = 3;

  localparam int COEF_CR_R = 359;
  localparam int COEF_CB_G = 88;
  localparam int COEF_CR_G = 183;
  localparam int COEF_CB_B = 454;
  localparam int ROUND_Q8  = 128;

  typedef enum logic [3:0] {
    S_IDLE, S_RD0, S_RD1, S_RD2, S_CAP, S_CALC, S_WR0, S_WR1, S_WR2, S_DONE
  } state_t;

  // Block b owns words 3b (Y/R), 3b+1 (Cb/G), 3b+2 (Cr/B).
  function automatic logic [SRAM_AW-1:0] blk_addr(input logic [SRAM_AW-1:0] blk,
                                                  input logic [1:0] plane);
    return blk * SRAM_AW'(WORDS_PER_BLK) + {{(SRAM_AW-2){1'b0}}, plane};
  endfunction

  // Floor-divide a Q8 sum by 256 and saturate to an 8-bit sample.
  function automatic logic [7:0] clamp_q8(input logic signed [17:0] s);
    logic signed [9:0] q;
    q = s[17:8];
    if (q < 0)
      return 8'd0;
    if (q > 10'sd255)
      return 8'hFF;
    return q[7:0];
  endfunction

endpackage

// File: rtl/ycbcr2rgb_2d_if.sv
// Source/destination SRAM port set shared by the colour-space stages,
// plus the enable/valid handshake of the block.
interface ycbcr2rgb_2d_if;
  import jpeg_pkg::*;

  logic                 enable;
  logic                 valid;
  logic [WORD_W-1:0]    data_read;
  logic [SRAM_AW-1:0]   sram_raddr;
  logic [SRAM_AW-1:0]   sram_waddr;
  logic [WORD_W-1:0]    data_write;
  logic                 wen;

  modport master (
    input  enable, data_read,
    output sram_raddr, sram_waddr, data_write, wen, valid
  );

  modport slave (
    output enable, data_read,
    input  sram_raddr, sram_waddr, data_write, wen, valid
  );

endinterface

// File: rtl/ycc2rgb_pixel.sv
// Combinational JFIF YCbCr -> RGB for one pixel in Q8 fixed point,
// floor-shifted and clamped to [0,255].
module ycc2rgb_pixel
  import jpeg_pkg::*;
(
  input  logic [7:0] y,
  input  logic [7:0] cb,
  input  logic [7:0] cr,
  output logic [7:0] r,
  output logic [7:0] g,
  output logic [7:0] b
);

  localparam logic signed [17:0] K_CR_R = 18'(COEF_CR_R);
  localparam logic signed [17:0] K_CB_G = 18'(COEF_CB_G);
  localparam logic signed [17:0] K_CR_G = 18'(COEF_CR_G);
  localparam logic signed [17:0] K_CB_B = 18'(COEF_CB_B);
  localparam logic signed [17:0] K_RND  = 18'(ROUND_Q8);

  logic signed [17:0] y_s;
  logic signed [17:0] cb_s;
  logic signed [17:0] cr_s;
  logic signed [17:0] sum_r;
  logic signed [17:0] sum_g;
  logic signed [17:0] sum_b;

  assign y_s  = $signed({2'b00, y, 8'h00});
  assign cb_s = $signed({10'd0, cb}) - 18'sd128;
  assign cr_s = $signed({10'd0, cr}) - 18'sd128;

  // Worst-case sums stay inside 18-bit signed range, so no guard bits are needed.
  assign sum_r = y_s + K_CR_R * cr_s + K_RND;
  assign sum_g = y_s - K_CB_G * cb_s - K_CR_G * cr_s + K_RND;
  assign sum_b = y_s + K_CB_B * cb_s + K_RND;

  assign r = clamp_q8(sum_r);
  assign g = clamp_q8(sum_g);
  assign b = clamp_q8(sum_b);

endmodule

// File: rtl/ycbcr2rgb_2d.sv
// Block-sequential YCbCr -> RGB stage: reads 3 plane words per 8x8 block,
// converts 64 pixels in parallel and writes back the R/G/B plane words.
//
// state  | meaning
// IDLE   | waiting for enable, outputs parked
// RD0-2  | read addresses 3b, 3b+1, 3b+2 presented
// CAP    | last read word (Cr) arrives
// CALC   | 64 pixel conversions, results registered
// WR0-2  | write R, G, B plane words (wen low)
// DONE   | valid high until enable drops
module ycbcr2rgb_2d
  import jpeg_pkg::*;
#(
  parameter int NUM_BLOCKS = 512
) (
  input  logic clk,
  input  logic rst_n,
  ycbcr2rgb_2d_if.master bus
);

  localparam logic [SRAM_AW-1:0] LAST_BLK = SRAM_AW'(NUM_BLOCKS - 1);

  state_t             state;
  logic [SRAM_AW-1:0] blk;
  logic [WORD_W-1:0]  y_q;
  logic [WORD_W-1:0]  cb_q;
  logic [WORD_W-1:0]  cr_q;
  logic [WORD_W-1:0]  g_q;
  logic [WORD_W-1:0]  b_q;
  logic [WORD_W-1:0]  r_w;
  logic [WORD_W-1:0]  g_w;
  logic [WORD_W-1:0]  b_w;

  for (genvar k = 0; k < PIX_PER_WORD; k++) begin : g_pix
    localparam int MSB = WORD_W - 1 - SAMPLE_W * k;
    ycc2rgb_pixel u_pix (
      .y  (y_q [MSB -: SAMPLE_W]),
      .cb (cb_q[MSB -: SAMPLE_W]),
      .cr (cr_q[MSB -: SAMPLE_W]),
      .r  (r_w [MSB -: SAMPLE_W]),
      .g  (g_w [MSB -: SAMPLE_W]),
      .b  (b_w [MSB -: SAMPLE_W])
    );
  end

  // Addresses are registered one state ahead so each RD/WR state sees its own address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      blk            <= '0;
      y_q            <= '0;
      cb_q           <= '0;
      cr_q           <= '0;
      g_q            <= '0;
      b_q            <= '0;
      bus.sram_raddr <= '0;
      bus.sram_waddr <= '0;
      bus.data_write <= '0;
      bus.wen        <= 1'b1;
      bus.valid      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          bus.valid <= 1'b0;
          bus.wen   <= 1'b1;
          if (bus.enable) begin
            blk            <= '0;
            bus.sram_raddr <= blk_addr('0, 2'd0);
            state          <= S_RD0;
          end
        end
        S_RD0: begin
          bus.sram_raddr <= blk_addr(blk, 2'd1);
          state          <= S_RD1;
        end
        S_RD1: begin
          y_q            <= bus.data_read;
          bus.sram_raddr <= blk_addr(blk, 2'd2);
          state          <= S_RD2;
        end
        S_RD2: begin
          cb_q  <= bus.data_read;
          state <= S_CAP;
        end
        S_CAP: begin
          cr_q  <= bus.data_read;
          state <= S_CALC;
        end
        S_CALC: begin
          g_q            <= g_w;
          b_q            <= b_w;
          bus.data_write <= r_w;
          bus.sram_waddr <= blk_addr(blk, 2'd0);
          bus.wen        <= 1'b0;
          state          <= S_WR0;
        end
        S_WR0: begin
          bus.data_write <= g_q;
          bus.sram_waddr <= blk_addr(blk, 2'd1);
          state          <= S_WR1;
        end
        S_WR1: begin
          bus.data_write <= b_q;
          bus.sram_waddr <= blk_addr(blk, 2'd2);
          state          <= S_WR2;
        end
        S_WR2: begin
          bus.wen <= 1'b1;
          if (blk == LAST_BLK) begin
            state <= S_DONE;
          end else begin
            blk            <= blk + 1'b1;
            bus.sram_raddr <= blk_addr(blk + 1'b1, 2'd0);
            state          <= S_RD0;
          end
        end
        S_DONE: begin
          // valid is shown for at least one cycle even if enable already dropped.
          bus.valid <= 1'b1;
          if (bus.valid && !bus.enable) begin
            bus.valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: begin
          bus.wen <= 1'b1;
          state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ycbcr2rgb_2d.sv
// Directed bench for ycbcr2rgb_2d: a 1-block and a 2-block instance share one
// source memory; written words are checked against a plain-integer colour model.
module tb_ycbcr2rgb_2d;
  import jpeg_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic en = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  ycbcr2rgb_2d_if bus1 ();
  ycbcr2rgb_2d_if bus2 ();

  assign bus1.enable = en;
  assign bus2.enable = en;

  ycbcr2rgb_2d #(.NUM_BLOCKS(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.master));
  ycbcr2rgb_2d #(.NUM_BLOCKS(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2.master));

  logic [511:0] src  [0:7];
  logic [511:0] dst1 [0:7];
  logic [511:0] dst2 [0:7];

  typedef struct {
    logic [10:0]  a;
    logic [511:0] d;
  } wr_t;
  wr_t q1[$];
  wr_t q2[$];

  always @(posedge clk) begin
    bus1.data_read <= (bus1.sram_raddr < 11'd8) ? src[bus1.sram_raddr[2:0]] : '0;
    bus2.data_read <= (bus2.sram_raddr < 11'd8) ? src[bus2.sram_raddr[2:0]] : '0;
  end

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Colour model straight from the JFIF Q8 formulas, floor division by 256.
  function automatic int px(input int y, input int cb, input int cr, input int plane);
    int s;
    int q;
    case (plane)
      0:       s = y * 256 + 359 * (cr - 128) + 128;
      1:       s = y * 256 - 88 * (cb - 128) - 183 * (cr - 128) + 128;
      default: s = y * 256 + 454 * (cb - 128) + 128;
    endcase
    q = s / 256;
    if (s < 0 && (s % 256) != 0) q = q - 1;
    if (q < 0) q = 0;
    if (q > 255) q = 255;
    return q;
  endfunction

  function automatic logic [511:0] model_word(input logic [511:0] yw, input logic [511:0] cbw,
                                              input logic [511:0] crw, input int plane);
    logic [511:0] w;
    w = '0;
    for (int k = 0; k < 64; k++)
      w[511-8*k -: 8] = 8'(px(int'(yw[511-8*k -: 8]), int'(cbw[511-8*k -: 8]),
                              int'(crw[511-8*k -: 8]), plane));
    return w;
  endfunction

  // Single compare process: every write on either instance is matched against the model queue.
  always @(negedge clk) begin
    wr_t e;
    if (rst_n && bus1.wen === 1'b0) begin
      if (q1.size() == 0) chk("dut1 unexpected write", {501'd0, bus1.sram_waddr}, 512'd0);
      else begin
        e = q1.pop_front();
        chk("dut1 waddr", {501'd0, bus1.sram_waddr}, {501'd0, e.a});
        chk("dut1 wdata", bus1.data_write, e.d);
        dst1[bus1.sram_waddr[2:0]] = bus1.data_write;
      end
    end
    if (rst_n && bus2.wen === 1'b0) begin
      if (q2.size() == 0) chk("dut2 unexpected write", {501'd0, bus2.sram_waddr}, 512'd0);
      else begin
        e = q2.pop_front();
        chk("dut2 waddr", {501'd0, bus2.sram_waddr}, {501'd0, e.a});
        chk("dut2 wdata", bus2.data_write, e.d);
        dst2[bus2.sram_waddr[2:0]] = bus2.data_write;
      end
    end
  end

  task automatic push_expect();
    for (int b = 0; b < 2; b++)
      for (int p = 0; p < 3; p++) begin
        q2.push_back('{11'(3*b+p), model_word(src[3*b], src[3*b+1], src[3*b+2], p)});
        if (b == 0) q1.push_back('{11'(p), model_word(src[0], src[1], src[2], p)});
      end
  endtask

  task automatic fill_random();
    for (int i = 0; i < 6; i++)
      for (int j = 0; j < 16; j++) src[i][32*j +: 32] = $urandom;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " raddr"}, {501'd0, bus2.sram_raddr}, 512'd0);
    chk({tag, " waddr"}, {501'd0, bus2.sram_waddr}, 512'd0);
    chk({tag, " data_write"}, bus2.data_write, 512'd0);
    chk({tag, " wen"}, {511'd0, bus2.wen}, 512'd1);
    chk({tag, " valid"}, {511'd0, bus2.valid}, 512'd0);
    chk({tag, " dut1 wen"}, {511'd0, bus1.wen}, 512'd1);
  endtask

  // c counts rising edges after the enable-sampling edge (c=0 is RD0 of block 0).
  task automatic run_blocks(input int drop_at);
    int b;
    int p;
    push_expect();
    @(negedge clk);
    en = 1'b1;
    for (int c = 0; c <= 17; c++) begin
      @(negedge clk);
      b = c / 8;
      p = c % 8;
      if (c < 16 && p < 3)
        chk("dut2 raddr", {501'd0, bus2.sram_raddr}, 512'(3*b+p));
      if (c < 8 && p < 3)
        chk("dut1 raddr", {501'd0, bus1.sram_raddr}, 512'(p));
      chk("dut2 wen", {511'd0, bus2.wen}, (c < 16 && p >= 5) ? 512'd0 : 512'd1);
      chk("dut2 valid", {511'd0, bus2.valid}, (c >= 17) ? 512'd1 : 512'd0);
      if (c <= 9)
        chk("dut1 valid", {511'd0, bus1.valid}, (c == 9) ? 512'd1 : 512'd0);
      if (c == drop_at) en = 1'b0;
    end
    chk("dut2 writes left", 512'(q2.size()), 512'd0);
    chk("dut1 writes left", 512'(q1.size()), 512'd0);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin
      src[i] = '0;
      dst1[i] = '0;
      dst2[i] = '0;
    end
    src[0] = {64{8'h80}};
    src[1] = {64{8'h80}};
    src[2] = {64{8'h80}};
    for (int k = 0; k < 64; k++) begin
      if (k % 4 == 0) begin
        src[3][511-8*k -: 8] = 8'h00;
        src[4][511-8*k -: 8] = 8'h80;
        src[5][511-8*k -: 8] = 8'hFF;
      end else if (k % 4 == 1) begin
        src[3][511-8*k -: 8] = 8'hFF;
        src[4][511-8*k -: 8] = 8'hFF;
        src[5][511-8*k -: 8] = 8'hFF;
      end else begin
        src[3][511-8*k -: 8] = 8'($urandom);
        src[4][511-8*k -: 8] = 8'($urandom);
        src[5][511-8*k -: 8] = 8'($urandom);
      end
    end

    // Pin the model to hand-computed values.
    chk("model R(0,80,FF)", 512'(px(0, 128, 255, 0)), 512'd178);
    chk("model G(0,80,FF)", 512'(px(0, 128, 255, 1)), 512'd0);
    chk("model G(FF,FF,FF)", 512'(px(255, 255, 255, 1)), 512'd121);
    chk("model B(FF,FF,FF)", 512'(px(255, 255, 255, 2)), 512'd255);

    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Grey block, then clamp corner cases in block 1.
    run_blocks(-1);
    chk("grey R", dst2[0], {64{8'h80}});
    chk("grey G", dst2[1], {64{8'h80}});
    chk("grey B", dst2[2], {64{8'h80}});
    chk("dut1 grey G", dst1[1], {64{8'h80}});
    chk("px0 R", {504'd0, dst2[3][511 -: 8]}, 512'hB2);
    chk("px0 G", {504'd0, dst2[4][511 -: 8]}, 512'h00);
    chk("px0 B", {504'd0, dst2[5][511 -: 8]}, 512'h00);
    chk("px1 R", {504'd0, dst2[3][503 -: 8]}, 512'hFF);
    chk("px1 G", {504'd0, dst2[4][503 -: 8]}, 512'h79);
    chk("px1 B", {504'd0, dst2[5][503 -: 8]}, 512'hFF);

    // enable held high: no restart, valid stays up.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("hold valid", {511'd0, bus2.valid}, 512'd1);
      chk("hold wen", {511'd0, bus2.wen}, 512'd1);
    end
    en = 1'b0;
    @(negedge clk);
    chk("drop valid", {511'd0, bus2.valid}, 512'd0);
    chk("dut1 drop valid", {511'd0, bus1.valid}, 512'd0);

    // Full rerun with enable deasserted mid-run (must not abort).
    fill_random();
    run_blocks(3);
    @(negedge clk);
    chk("post-run valid low", {511'd0, bus2.valid}, 512'd0);

    // Reset during WR1 of block 0.
    fill_random();
    push_expect();
    @(negedge clk);
    en = 1'b1;
    repeat (7) @(negedge clk);
    #2;
    rst_n = 1'b0;
    en = 1'b0;
    #1;
    chk_reset_outputs("midrun reset");
    q1.delete();
    q2.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("idle after reset wen", {511'd0, bus2.wen}, 512'd1);
    fill_random();
    run_blocks(-1);
    en = 1'b0;
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
